sparse_stream_feeder: RTL

Edge feeder for the sparse systolic array. It takes one dense vector of N = 2^INDEX_SIZE fixed-point elements over a valid/ready handshake and compacts the nonzero elements into a buffer. It then streams them as (value, index) pairs, in strictly ascending index order and one per cycle, into the up or left input of an edge sparse PE. The stream ends with a zero value, which the PE reads as its finish condition. A per-instance skew delay aligns rows/columns for systolic wavefront entry.

---
 rtl/sparse_stream_feeder_if.sv | 36 +++
 rtl/sparse_stream_feeder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sparse_stream_feeder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sparse_stream_feeder_if
//  Purpose  : Bundles the dense-load handshake and the sparse (value, index)
//             stream of sparse_stream_feeder into one interface.
//  Signals  : i_valid/i_ready/i_data  - dense element handshake (producer side)
//             o_data/o_index          - streamed pair toward the edge PE
//             o_busy/o_done           - feeder activity / terminator pulse
//  Modports : slave  - the feeder's view
//             master - the producer/consumer view (testbench, upstream logic)
//  Revision : 1.0 - initial release
// ============================================================================
interface sparse_stream_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int INDEX_SIZE = 3
);
  logic                  i_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic [INDEX_SIZE-1:0] o_index;
  logic                  o_busy;
  logic                  o_done;

  modport slave (
    input  i_valid, i_data,
    output i_ready, o_data, o_index, o_busy, o_done
  );

  modport master (
    output i_valid, i_data,
    input  i_ready, o_data, o_index, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/sparse_stream_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sparse_stream_feeder
//  Purpose  : Loads one dense vector of N = 2^INDEX_SIZE elements, compacts
//             the nonzero elements into a buffer, waits SKEW cycles and then
//             streams them as (value, index) pairs, ascending index, one per
//             cycle, followed by a zero terminator with a one-cycle o_done.
//  Ports    : clk  - clock, all logic on posedge
//             rst  - synchronous active-high reset
//             bus  - sparse_stream_feeder_if.slave:
//                    i_valid/i_ready/i_data dense input handshake,
//                    o_data/o_index stream pair (0 = none / terminator),
//                    o_busy (SKEW/STREAM/TERM), o_done (terminator pulse)
//  Revision : 1.0 - initial release
// ============================================================================
module sparse_stream_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int INDEX_SIZE = 3,
  parameter int SKEW       = 0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  sparse_stream_feeder_if.slave  bus
);

  localparam int N  = 1 << INDEX_SIZE;
  localparam int EW = INDEX_SIZE + DATA_WIDTH;

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_SKEW   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_TERM   = 2'd3;

  localparam logic [3:0]            SKEW_LAST = (SKEW > 0) ? 4'(SKEW - 1) : 4'd0;
  localparam logic [INDEX_SIZE-1:0] LAST_BEAT = INDEX_SIZE'(N - 1);

  logic [1:0]            state_q, state_d;
  logic [INDEX_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [INDEX_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [INDEX_SIZE:0]   nz_cnt_q, nz_cnt_d;
  logic [3:0]            skew_cnt_q, skew_cnt_d;

  // Compacted entries {index, value}; not reset, only entries below nz_cnt are read.
  logic [EW-1:0]         buffer_q [N];

  logic                  ready_w;
  logic                  accept_w;
  logic                  beat_nz_w;
  logic [INDEX_SIZE:0]   nz_after_w;
  logic [INDEX_SIZE:0]   rd_inc_w;
  logic [EW-1:0]         entry_w;

  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic [INDEX_SIZE-1:0] o_index_q, o_index_d;
  logic                  o_busy_q, o_busy_d;
  logic                  o_done_q, o_done_d;

  assign accept_w   = bus.i_valid && ready_w;
  assign beat_nz_w  = |bus.i_data;
  assign nz_after_w = nz_cnt_q + {{INDEX_SIZE{1'b0}}, beat_nz_w};
  assign rd_inc_w   = {1'b0, rd_ptr_q} + (INDEX_SIZE + 1)'(1);

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      nz_cnt_q   <= '0;
      skew_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      nz_cnt_q   <= nz_cnt_d;
      skew_cnt_q <= skew_cnt_d;
    end
  end

  // Compaction write: nonzero beats land at the next free slot, so slot order
  // equals arrival order, which is ascending index order.
  always_ff @(posedge clk) begin
    if (accept_w && beat_nz_w) begin
      buffer_q[nz_cnt_q[INDEX_SIZE-1:0]] <= {wr_ptr_q, bus.i_data};
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    nz_cnt_d   = nz_cnt_q;
    skew_cnt_d = skew_cnt_q;
    case (state_q)
      S_LOAD: begin
        if (accept_w) begin
          wr_ptr_d = wr_ptr_q + INDEX_SIZE'(1);
          nz_cnt_d = nz_after_w;
          if (wr_ptr_q == LAST_BEAT) begin
            rd_ptr_d   = '0;
            skew_cnt_d = '0;
            if (SKEW > 0)             state_d = S_SKEW;
            else if (nz_after_w != 0) state_d = S_STREAM;
            else                      state_d = S_TERM;
          end
        end
      end
      S_SKEW: begin
        if (skew_cnt_q == SKEW_LAST) begin
          state_d = (nz_cnt_q != 0) ? S_STREAM : S_TERM;
        end else begin
          skew_cnt_d = skew_cnt_q + 4'd1;
        end
      end
      S_STREAM: begin
        // rd_ptr names the entry currently on the outputs
        if (rd_inc_w < nz_cnt_q) rd_ptr_d = rd_ptr_q + INDEX_SIZE'(1);
        else                     state_d  = S_TERM;
      end
      default: begin
        state_d  = S_LOAD;
        wr_ptr_d = '0;
        nz_cnt_d = '0;
      end
    endcase
  end

  // Output logic: outputs are registered, so the next values are decoded
  // from the next state and next read pointer.
  always_comb begin
    ready_w   = (state_q == S_LOAD) && !rst;
    o_data_d  = '0;
    o_index_d = '0;
    o_busy_d  = (state_d != S_LOAD);
    o_done_d  = (state_d == S_TERM);
    // Entering STREAM straight from LOAD with an empty buffer means the only
    // entry is the beat being accepted now; it is not in the buffer yet.
    if ((state_q == S_LOAD) && (nz_cnt_q == 0)) entry_w = {wr_ptr_q, bus.i_data};
    else                                        entry_w = buffer_q[rd_ptr_d];
    if (state_d == S_STREAM) begin
      o_index_d = entry_w[EW-1:DATA_WIDTH];
      o_data_d  = entry_w[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_data_q  <= '0;
      o_index_q <= '0;
      o_busy_q  <= 1'b0;
      o_done_q  <= 1'b0;
    end else begin
      o_data_q  <= o_data_d;
      o_index_q <= o_index_d;
      o_busy_q  <= o_busy_d;
      o_done_q  <= o_done_d;
    end
  end

  assign bus.i_ready = ready_w;
  assign bus.o_data  = o_data_q;
  assign bus.o_index = o_index_q;
  assign bus.o_busy  = o_busy_q;
  assign bus.o_done  = o_done_q;

endmodule
`default_nettype wire
